// File: rtl/axi_seq_pkg.sv
// axi_seq_pkg: burst/state enums, queued request record, and per-beat address and strobe arithmetic
package axi_seq_pkg;
  typedef enum logic [1:0] {B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10, B_RSVD = 2'b11} burst_e;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int MAX_MASTERS = 64;
  localparam int MAX_ID = 32;
  localparam int MAX_WIDTH = 64;
  typedef struct packed {
    logic [MAX_MASTERS-1:0] master;
    logic [MAX_ID-1:0] id;
    logic [MAX_WIDTH-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    burst_e burst;
  } req_t;
  function automatic logic [11:0] next_addr(input logic [11:0] a, input logic [2:0] esize, input burst_e b, input logic [11:0] tot);
    logic [11:0] bpb;
    bpb = 12'd1 << esize;
    return b == B_FIXED ? a : b == B_WRAP ? (a & ~(tot - 12'd1)) | ((a + bpb) & (tot - 12'd1)) : (a & ~(bpb - 12'd1)) + bpb;
  endfunction
  function automatic logic [127:0] strb_gen(input logic [6:0] addr, input logic [2:0] esize, input logic [2:0] psize);
    logic [7:0] lanes, lo, hi;
    logic [127:0] s;
    lanes = 8'd1 << psize;
    lo = {1'b0, addr} & (lanes - 8'd1);
    hi = ({1'b0, addr} & ~((8'd1 << esize) - 8'd1) & (lanes - 8'd1)) + (8'd1 << esize);
    for (int i = 0; i < 128; i++) s[i] = (i >= int'(lo)) && (i < int'(hi));
    return s;
  endfunction
endpackage

// File: rtl/axi_burst_sequencer_if.sv
// axi_burst_sequencer_if: request channel (MASTER/ID/ADDR/LEN/SIZE/BURST/VALID/READY), beat channel (O_*), BUSY
interface axi_burst_sequencer_if #(
  parameter int MASTERS = 4,
  parameter int ID_BITS = 4,
  parameter int WIDTH = 22,
  parameter int P_SIZE = 4
);
  logic [MASTERS-1:0] MASTER;
  logic [ID_BITS-1:0] ID;
  logic [WIDTH-1:0] ADDR;
  logic [7:0] LEN;
  logic [2:0] SIZE;
  logic [1:0] BURST;
  logic VALID;
  logic READY;
  logic [MASTERS-1:0] O_MASTER;
  logic [ID_BITS-1:0] O_ID;
  logic [WIDTH-1:0] O_ADDR;
  logic [(1<<P_SIZE)-1:0] O_STRB;
  logic O_LAST;
  logic O_VALID;
  logic O_READY;
  logic BUSY;
  modport slave (
    input MASTER, ID, ADDR, LEN, SIZE, BURST, VALID, O_READY,
    output READY, O_MASTER, O_ID, O_ADDR, O_STRB, O_LAST, O_VALID, BUSY
  );
  modport master (
    output MASTER, ID, ADDR, LEN, SIZE, BURST, VALID, O_READY,
    input READY, O_MASTER, O_ID, O_ADDR, O_STRB, O_LAST, O_VALID, BUSY
  );
endinterface

// File: rtl/axi_req_fifo.sv
// axi_req_fifo: DEPTH-entry request queue; CLK, async RESETN, push/din in, pop in, dout/full/empty out
module axi_req_fifo
  import axi_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic CLK,
  input logic RESETN,
  input logic push,
  input req_t din,
  input logic pop,
  output req_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  req_t mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (pop) rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  always_ff @(posedge CLK)
    if (push) mem[wp[AW-1:0]] <= din;
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/axi_burst_sequencer.sv
// axi_burst_sequencer: CLK, async RESETN, bus.slave; queues AXI requests and emits one address/strobe/LAST beat per cycle
module axi_burst_sequencer
  import axi_seq_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int ID_BITS = 4,
  parameter int WIDTH = 22,
  parameter int P_SIZE = 4,
  parameter int DEPTH = 4
) (
  input logic CLK,
  input logic RESETN,
  axi_burst_sequencer_if.slave bus
);
  localparam int STRB_W = 1 << P_SIZE;
  state_e state, nxt;
  req_t wr, hd;
  logic full, empty, pop, rdy_en, last, acc;
  logic [MASTERS-1:0] cur_master;
  logic [ID_BITS-1:0] cur_id;
  logic [WIDTH-1:0] cur_addr;
  logic [2:0] cur_es, ld_es;
  burst_e cur_burst, ld_burst;
  logic [11:0] cur_tot, ld_tot;
  logic [15:0] cnt, last_cnt, ld_last;
  assign wr = {MAX_MASTERS'(bus.MASTER), MAX_ID'(bus.ID), MAX_WIDTH'(bus.ADDR), bus.LEN, bus.SIZE, bus.BURST};
  axi_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK(CLK),
    .RESETN(RESETN),
    .push(bus.VALID && bus.READY),
    .din(wr),
    .pop(pop),
    .dout(hd),
    .full(full),
    .empty(empty)
  );
  assign ld_es = (hd.size > 3'(P_SIZE)) ? 3'(P_SIZE) : hd.size;
  assign ld_last = (({8'd0, hd.len} + 16'd1) << (hd.size - ld_es)) - 16'd1;
  assign ld_tot = 12'(({8'd0, hd.len} + 16'd1) << hd.size);
  assign ld_burst = (hd.burst == B_WRAP && (hd.len == 8'd1 || hd.len == 8'd3 || hd.len == 8'd7 || hd.len == 8'd15)) ? B_WRAP :
                    hd.burst == B_FIXED ? B_FIXED : B_INCR;
  assign last = state == RUN && cnt == last_cnt;
  assign acc = state == RUN && bus.O_READY;
  always_comb begin
    pop = !empty && (state == IDLE || (acc && last));
    nxt = pop ? RUN : (acc && last) ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      state <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state <= nxt;
      rdy_en <= 1'b1;
    end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      cur_master <= '0;
      cur_id <= '0;
      cur_addr <= '0;
      cur_es <= '0;
      cur_burst <= B_FIXED;
      cur_tot <= '0;
      last_cnt <= '0;
      cnt <= '0;
    end else if (pop) begin
      cur_master <= MASTERS'(hd.master);
      cur_id <= ID_BITS'(hd.id);
      cur_addr <= WIDTH'(hd.addr);
      cur_es <= ld_es;
      cur_burst <= ld_burst;
      cur_tot <= ld_tot;
      last_cnt <= ld_last;
      cnt <= '0;
    end else if (acc && !last) begin
      cur_addr[11:0] <= next_addr(cur_addr[11:0], cur_es, cur_burst, cur_tot);
      cnt <= cnt + 16'd1;
    end
  assign bus.READY = rdy_en && !full;
  assign bus.BUSY = !empty || state == RUN;
  assign bus.O_VALID = state == RUN;
  assign bus.O_LAST = last;
  assign bus.O_MASTER = cur_master;
  assign bus.O_ID = cur_id;
  assign bus.O_ADDR = cur_addr;
  assign bus.O_STRB = STRB_W'(strb_gen(cur_addr[6:0], cur_es, 3'(P_SIZE)));
endmodule

// File: tb/tb_axi_burst_sequencer.sv
// tb_axi_burst_sequencer: directed and random bursts checked beat-by-beat against an arithmetic expansion model
module tb_axi_burst_sequencer;
  logic CLK = 1'b0;
  logic RESETN = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  bit rand_rdy = 0;
  bit stalled = 0;
  logic [47:0] hold;
  typedef struct {
    logic [3:0] m;
    logic [3:0] id;
    logic [21:0] a;
    logic [15:0] s;
    logic l;
  } beat_t;
  beat_t exp_q[$];
  axi_burst_sequencer_if #(.MASTERS(4), .ID_BITS(4), .WIDTH(22), .P_SIZE(4)) bus ();
  axi_burst_sequencer #(.MASTERS(4), .ID_BITS(4), .WIDTH(22), .P_SIZE(4), .DEPTH(4)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expand(input logic [3:0] m, input logic [3:0] id, input logic [21:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int es, bpb, beats, tot, page, a;
    bit wrap;
    es = size > 4 ? 4 : int'(size);
    bpb = 1 << es;
    beats = (int'(len) + 1) << (int'(size) - es);
    wrap = burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15);
    tot = beats * bpb;
    page = int'(addr) & ~32'hFFF;
    a = int'(addr) & 32'hFFF;
    for (int k = 0; k < beats; k++) begin
      beat_t bt;
      int lane, al;
      lane = a % 16;
      al = (a - a % bpb) % 16;
      bt.m = m;
      bt.id = id;
      bt.a = 22'(page + a);
      bt.l = k == beats - 1;
      for (int j = 0; j < 16; j++) bt.s[j] = j >= lane && j < al + bpb;
      exp_q.push_back(bt);
      if (burst != 2'b00) a = wrap ? a - a % tot + (a + bpb) % tot : (a - a % bpb + bpb) % 4096;
    end
  endtask
  task automatic send(input logic [3:0] m, input logic [3:0] id, input logic [21:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    bus.MASTER = m;
    bus.ID = id;
    bus.ADDR = a;
    bus.LEN = l;
    bus.SIZE = s;
    bus.BURST = b;
    bus.VALID = 1'b1;
    do begin
      @(negedge CLK);
      ok = bus.READY;
      @(posedge CLK);
      #1;
      n++;
      if (rand_rdy) bus.O_READY = 1'($urandom_range(0, 1));
    end while (!ok && n < 3000);
    bus.VALID = 1'b0;
    if (ok) expand(m, id, a, l, s, b);
    else check("send_timeout", 64'(ok), 64'd1);
  endtask
  task automatic send_rand();
    logic [2:0] s;
    logic [1:0] b;
    logic [21:0] a;
    s = 3'($urandom_range(0, 6));
    b = 2'($urandom_range(0, 3));
    a = 22'($urandom);
    if (b == 2'b10) a = (a >> s) << s;
    send(4'd1 << $urandom_range(0, 3), 4'($urandom), a, 8'($urandom_range(0, 15)), s, b);
  endtask
  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge CLK);
      #1;
      n++;
      bus.O_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    bus.O_READY = 1'b1;
    @(posedge CLK);
    #1;
    check("idle_after_drain", 64'({bus.O_VALID, bus.BUSY}), 64'd0);
  endtask
  always @(negedge CLK) begin
    if (!RESETN) stalled = 0;
    else begin
      if (stalled) check("stall_hold", 64'({bus.O_VALID, bus.O_MASTER, bus.O_ID, bus.O_ADDR, bus.O_STRB, bus.O_LAST}), 64'(hold));
      if (bus.O_VALID && bus.O_READY) begin
        check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("o_master", 64'(bus.O_MASTER), 64'(e.m));
          check("o_id", 64'(bus.O_ID), 64'(e.id));
          check("o_addr", 64'(bus.O_ADDR), 64'(e.a));
          check("o_strb", 64'(bus.O_STRB), 64'(e.s));
          check("o_last", 64'(bus.O_LAST), 64'(e.l));
        end
      end
      stalled = bus.O_VALID && !bus.O_READY;
      hold = {bus.O_VALID, bus.O_MASTER, bus.O_ID, bus.O_ADDR, bus.O_STRB, bus.O_LAST};
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int total;
    bus.MASTER = '0;
    bus.ID = '0;
    bus.ADDR = '0;
    bus.LEN = '0;
    bus.SIZE = '0;
    bus.BURST = '0;
    bus.VALID = 1'b0;
    bus.O_READY = 1'b0;
    #1 RESETN = 1'b0;
    #2;
    check("rst_o_valid", 64'(bus.O_VALID), 64'd0);
    check("rst_o_last", 64'(bus.O_LAST), 64'd0);
    check("rst_busy", 64'(bus.BUSY), 64'd0);
    check("rst_ready", 64'(bus.READY), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    check("ready_after_release", 64'(bus.READY), 64'd1);
    bus.O_READY = 1'b1;
    send(4'h1, 4'h3, 22'h001004, 8'd3, 3'd2, 2'b01);
    check("latency_edge1", 64'(bus.O_VALID), 64'd0);
    @(posedge CLK);
    #1;
    check("latency_edge2", 64'(bus.O_VALID), 64'd1);
    drain(0);
    send(4'h2, 4'h5, 22'h000038, 8'd3, 3'd3, 2'b10);
    drain(0);
    send(4'h4, 4'h6, 22'h000000, 8'd1, 3'd5, 2'b01);
    drain(0);
    bus.O_READY = 1'b0;
    for (int i = 0; i < 5; i++) send_rand();
    @(negedge CLK);
    check("full_ready_low", 64'(bus.READY), 64'd0);
    check("full_busy", 64'(bus.BUSY), 64'd1);
    @(posedge CLK);
    #1;
    total = exp_q.size();
    bus.O_READY = 1'b1;
    repeat (total) @(posedge CLK);
    #1;
    check("b2b_no_bubble", 64'(exp_q.size()), 64'd0);
    check("b2b_idle_after", 64'(bus.O_VALID), 64'd0);
    drain(0);
    send(4'h8, 4'hA, 22'h003FF0, 8'd3, 3'd4, 2'b01);
    drain(1);
    rand_rdy = 1;
    repeat (20) send_rand();
    drain(1);
    rand_rdy = 0;
    bus.O_READY = 1'b0;
    for (int i = 0; i < 3; i++) send(4'h1, 4'(i), 22'h000100, 8'd3, 3'd2, 2'b01);
    @(posedge CLK);
    #2 RESETN = 1'b0;
    #1;
    check("midrst_o_valid", 64'(bus.O_VALID), 64'd0);
    check("midrst_busy", 64'(bus.BUSY), 64'd0);
    check("midrst_ready", 64'(bus.READY), 64'd0);
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_ready", 64'(bus.READY), 64'd1);
    check("post_rst_busy", 64'(bus.BUSY), 64'd0);
    bus.O_READY = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check("post_rst_no_beats", 64'({bus.O_VALID, bus.BUSY}), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
